// File: rtl/time_ui_pkg.sv
// Shared types, field codes and wrap/clamp helpers for the time-set user interface.
// Optional feature macro used by this slice: AUTOREPEAT_EN.
package time_ui_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEditH,
        StEditM,
        StEditS,
        StCommit
    } state_e;

    typedef struct packed {
        logic [5:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } hms_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HH   = 2'd1;
    localparam logic [1:0] FLD_MM   = 2'd2;
    localparam logic [1:0] FLD_SS   = 2'd3;

    localparam logic [5:0] MAX_HOURS   = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // up=1 increments, up=0 decrements; both wrap within 0..max_val
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max_val,
                                             input logic up);
        logic [5:0] res;
        if (up) begin
            res = (val >= max_val) ? 6'd0 : val + 6'd1;
        end else begin
            res = (val == 6'd0 || val > max_val) ? max_val : val - 6'd1;
        end
        return res;
    endfunction

    function automatic logic [5:0] clamp(input logic [5:0] val, input logic [5:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button, current-time and commit signals between the set controller and its neighbours.
// The controller is the master; the clock core / button side is the slave.
interface time_set_controller_if;
    logic       btn_time;
    logic       btn_alarm;
    logic       btn_next;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_cancel;
    logic [5:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       set_time;
    logic       set_alarm;
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       editing;
    logic [1:0] field;
    logic       alarm_target;

    modport master (
        input  btn_time, btn_alarm, btn_next, btn_inc, btn_dec, btn_cancel,
        input  cur_hours, cur_minutes, cur_seconds,
        output set_time, set_alarm, hours, minutes, seconds, editing, field, alarm_target
    );

    modport slave (
        output btn_time, btn_alarm, btn_next, btn_inc, btn_dec, btn_cancel,
        output cur_hours, cur_minutes, cur_seconds,
        input  set_time, set_alarm, hours, minutes, seconds, editing, field, alarm_target
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Rising-edge detector for a debounced button level, with optional autorepeat
// (built only when AUTOREPEAT_EN is defined and REPEAT_EN is set).
module btn_pulse_gen #(
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 50,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic repeat_ok,
    output logic pulse
);

    logic prev_q;
    logic edge_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_det = level & ~prev_q;

`ifdef AUTOREPEAT_EN
    localparam bit BuildRepeat = REPEAT_EN;
`else
    localparam bit BuildRepeat = 1'b0;
`endif

    if (BuildRepeat) begin : g_repeat
        localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                        : REPEAT_PERIOD;
        localparam int unsigned CntW   = $clog2(MaxCnt + 1);

        logic [CntW-1:0] cnt_q;
        logic            armed_q;
        logic            rep;

        // cnt_q equals cycles held since the edge (delay phase) or since the last step
        assign rep = level & repeat_ok & ~edge_det &
                     (armed_q ? (cnt_q == CntW'(REPEAT_PERIOD)) : (cnt_q == CntW'(REPEAT_DELAY)));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else if (!level || !repeat_ok) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else if (edge_det) begin
                cnt_q   <= CntW'(1);
                armed_q <= 1'b0;
            end else if (rep) begin
                cnt_q   <= CntW'(1);
                armed_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + CntW'(1);
            end
        end

        assign pulse = edge_det | rep;
    end else begin : g_edge_only
        logic unused_repeat_ok;
        assign unused_repeat_ok = repeat_ok;
        assign pulse = edge_det;
    end

endmodule

// File: rtl/time_set_controller.sv
// Edit-session FSM for the alarm clock's set interface: HH -> MM -> SS -> one-cycle commit.
// AUTOREPEAT_EN enables held-button autorepeat on inc/dec.
module time_set_controller
    import time_ui_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_PERIOD  = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    time_set_controller_if.master         bus
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    hms_t            stage_q, stage_d;
    hms_t            shadow_q;
    logic            tgt_q, tgt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic p_time, p_alarm, p_next, p_inc, p_dec, p_cancel;
    logic in_edit;

    assign in_edit = (state_q == StEditH) || (state_q == StEditM) || (state_q == StEditS);

    btn_pulse_gen #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_time   (.clk(clk), .reset(reset), .level(bus.btn_time),   .repeat_ok(1'b0),
                     .pulse(p_time));
    btn_pulse_gen #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_alarm  (.clk(clk), .reset(reset), .level(bus.btn_alarm),  .repeat_ok(1'b0),
                     .pulse(p_alarm));
    btn_pulse_gen #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_next   (.clk(clk), .reset(reset), .level(bus.btn_next),   .repeat_ok(1'b0),
                     .pulse(p_next));
    btn_pulse_gen #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_inc    (.clk(clk), .reset(reset), .level(bus.btn_inc),    .repeat_ok(in_edit),
                     .pulse(p_inc));
    btn_pulse_gen #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_dec    (.clk(clk), .reset(reset), .level(bus.btn_dec),    .repeat_ok(in_edit),
                     .pulse(p_dec));
    btn_pulse_gen #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_pg_cancel (.clk(clk), .reset(reset), .level(bus.btn_cancel), .repeat_ok(1'b0),
                     .pulse(p_cancel));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            stage_q  <= '0;
            shadow_q <= '0;
            tgt_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            if (state_q == StCommit && tgt_q) begin
                shadow_q <= stage_q;
            end
        end
    end

    always_comb begin
        logic       accepted;
        logic [5:0] fld_new;
        state_d  = state_q;
        stage_d  = stage_q;
        tgt_d    = tgt_q;
        tmo_d    = tmo_q;
        accepted = 1'b0;
        fld_new  = 6'd0;
        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (p_time) begin
                    stage_d.hours   = clamp(bus.cur_hours, MAX_HOURS);
                    stage_d.minutes = clamp(bus.cur_minutes, MAX_MIN_SEC);
                    stage_d.seconds = clamp(bus.cur_seconds, MAX_MIN_SEC);
                    tgt_d   = 1'b0;
                    state_d = StEditH;
                end else if (p_alarm) begin
                    stage_d = shadow_q;
                    tgt_d   = 1'b1;
                    state_d = StEditH;
                end
            end
            StEditH, StEditM, StEditS: begin
                tmo_d = tmo_q + TmoW'(1);
                if (p_cancel) begin
                    accepted = 1'b1;
                    state_d  = StIdle;
                end else if (p_next) begin
                    accepted = 1'b1;
                    state_d  = (state_q == StEditH) ? StEditM :
                               (state_q == StEditM) ? StEditS : StCommit;
                end else if (p_inc || p_dec) begin
                    accepted = 1'b1;
                    // Simultaneous inc and dec is accepted but leaves the value alone
                    if (p_inc ^ p_dec) begin
                        if (state_q == StEditH) begin
                            fld_new = wrap_step(stage_q.hours, MAX_HOURS, p_inc);
                            stage_d.hours = fld_new;
                        end else if (state_q == StEditM) begin
                            fld_new = wrap_step(stage_q.minutes, MAX_MIN_SEC, p_inc);
                            stage_d.minutes = fld_new;
                        end else begin
                            fld_new = wrap_step(stage_q.seconds, MAX_MIN_SEC, p_inc);
                            stage_d.seconds = fld_new;
                        end
                    end
                end
                if (accepted) begin
                    tmo_d = '0;
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                end
            end
            StCommit: begin
                tmo_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.set_time     = (state_q == StCommit) & ~tgt_q;
        bus.set_alarm    = (state_q == StCommit) & tgt_q;
        bus.hours        = stage_q.hours;
        bus.minutes      = stage_q.minutes;
        bus.seconds      = stage_q.seconds;
        bus.editing      = (state_q != StIdle);
        bus.alarm_target = tgt_q;
        bus.field        = FLD_NONE;
        unique case (state_q)
            StEditH: bus.field = FLD_HH;
            StEditM: bus.field = FLD_MM;
            StEditS: bus.field = FLD_SS;
            default: bus.field = FLD_NONE;
        endcase
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed self-checking bench for time_set_controller; outputs sampled on the falling edge.
module tb_time_set_controller;

    localparam logic [5:0] B_TIME   = 6'b000001;
    localparam logic [5:0] B_ALARM  = 6'b000010;
    localparam logic [5:0] B_NEXT   = 6'b000100;
    localparam logic [5:0] B_INC    = 6'b001000;
    localparam logic [5:0] B_DEC    = 6'b010000;
    localparam logic [5:0] B_CANCEL = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn;
    logic [5:0] cur_h, cur_m, cur_s;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    time_set_controller_if bus ();

    assign bus.btn_time    = btn[0];
    assign bus.btn_alarm   = btn[1];
    assign bus.btn_next    = btn[2];
    assign bus.btn_inc     = btn[3];
    assign bus.btn_dec     = btn[4];
    assign bus.btn_cancel  = btn[5];
    assign bus.cur_hours   = cur_h;
    assign bus.cur_minutes = cur_m;
    assign bus.cur_seconds = cur_s;

    time_set_controller #(
        .TIMEOUT_CYCLES(1000),
        .REPEAT_DELAY  (50),
        .REPEAT_PERIOD (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Level high for exactly one rising edge, then low; returns on the falling edge after it
    task automatic press(input logic [5:0] mask);
        @(negedge clk);
        btn = mask;
        @(negedge clk);
        btn = '0;
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        cur_h = 6'd12;
        cur_m = 6'd34;
        cur_s = 6'd56;
        repeat (2) @(negedge clk);
        check("rst_editing", int'(bus.editing), 0);
        check("rst_field", int'(bus.field), 0);
        check("rst_hours", int'(bus.hours), 0);
        check("rst_set_time", int'(bus.set_time), 0);
        check("rst_set_alarm", int'(bus.set_alarm), 0);
        reset = 1'b0;

        // Time edit from 12:34:56, +2 hours, commit
        press(B_TIME);
        check("t1_editing", int'(bus.editing), 1);
        check("t1_field_hh", int'(bus.field), 1);
        check("t1_load_hours", int'(bus.hours), 12);
        check("t1_target", int'(bus.alarm_target), 0);
        press(B_INC);
        press(B_INC);
        check("t1_hours_inc", int'(bus.hours), 14);
        press(B_NEXT);
        check("t1_field_mm", int'(bus.field), 2);
        press(B_NEXT);
        check("t1_field_ss", int'(bus.field), 3);
        press(B_NEXT);
        check("t1_set_time", int'(bus.set_time), 1);
        check("t1_set_alarm", int'(bus.set_alarm), 0);
        check("t1_hours", int'(bus.hours), 14);
        check("t1_minutes", int'(bus.minutes), 34);
        check("t1_seconds", int'(bus.seconds), 56);
        @(negedge clk);
        check("t1_strobe_len", int'(bus.set_time), 0);
        check("t1_idle", int'(bus.editing), 0);

        // Alarm edit from a zero shadow, HH wraps 0 -> 23
        press(B_ALARM);
        check("t2_target", int'(bus.alarm_target), 1);
        check("t2_load_hours", int'(bus.hours), 0);
        press(B_DEC);
        check("t2_hours_wrap", int'(bus.hours), 23);
        press(B_NEXT);
        press(B_NEXT);
        press(B_NEXT);
        check("t2_set_alarm", int'(bus.set_alarm), 1);
        check("t2_set_time", int'(bus.set_time), 0);
        check("t2_hours", int'(bus.hours), 23);
        check("t2_minutes", int'(bus.minutes), 0);
        check("t2_seconds", int'(bus.seconds), 0);
        @(negedge clk);
        check("t2_strobe_len", int'(bus.set_alarm), 0);
        press(B_ALARM);
        check("t2_shadow_hours", int'(bus.hours), 23);
        check("t2_shadow_minutes", int'(bus.minutes), 0);
        press(B_CANCEL);
        check("t2_cancel", int'(bus.editing), 0);

        // Minute and second wrap, inc+dec together
        cur_h = 6'd10;
        cur_m = 6'd59;
        cur_s = 6'd0;
        press(B_TIME);
        press(B_NEXT);
        check("t3_load_minutes", int'(bus.minutes), 59);
        press(B_INC);
        check("t3_minutes_wrap", int'(bus.minutes), 0);
        check("t3_hours_kept", int'(bus.hours), 10);
        press(B_NEXT);
        check("t3_load_seconds", int'(bus.seconds), 0);
        press(B_DEC);
        check("t3_seconds_wrap", int'(bus.seconds), 59);
        press(B_INC | B_DEC);
        check("t3_inc_dec", int'(bus.seconds), 59);
        press(B_CANCEL);
        check("t3_cancel", int'(bus.editing), 0);
        check("t3_no_strobe", int'(bus.set_time), 0);

        // Cancel in EDIT_M, then timeout in EDIT_S
        press(B_TIME);
        press(B_NEXT);
        check("t4_field_mm", int'(bus.field), 2);
        press(B_CANCEL);
        check("t4_cancel_idle", int'(bus.editing), 0);
        check("t4_cancel_nostrobe", int'(bus.set_time), 0);
        @(negedge clk);
        check("t4_cancel_nostrobe2", int'(bus.set_time), 0);
        press(B_TIME);
        press(B_NEXT);
        press(B_NEXT);
        check("t4_field_ss", int'(bus.field), 3);
        repeat (999) @(negedge clk);
        check("t4_before_timeout", int'(bus.editing), 1);
        @(negedge clk);
        check("t4_timeout_idle", int'(bus.editing), 0);
        check("t4_timeout_set_time", int'(bus.set_time), 0);
        check("t4_timeout_set_alarm", int'(bus.set_alarm), 0);

        // Asynchronous reset mid-session, then time/alarm together
        cur_h = 6'd12;
        cur_m = 6'd34;
        cur_s = 6'd56;
        press(B_TIME);
        press(B_NEXT);
        press(B_NEXT);
        check("t5_field_ss", int'(bus.field), 3);
        #2 reset = 1'b1;
        @(negedge clk);
        check("t5_rst_editing", int'(bus.editing), 0);
        check("t5_rst_field", int'(bus.field), 0);
        check("t5_rst_hours", int'(bus.hours), 0);
        check("t5_rst_minutes", int'(bus.minutes), 0);
        check("t5_rst_seconds", int'(bus.seconds), 0);
        reset = 1'b0;
        press(B_TIME | B_ALARM);
        check("t5_both_target", int'(bus.alarm_target), 0);
        check("t5_both_hours", int'(bus.hours), 12);
        check("t5_both_editing", int'(bus.editing), 1);
        press(B_CANCEL);

`ifdef AUTOREPEAT_EN
        // Hold inc: edge step, one after the delay, then three periods
        cur_h = 6'd0;
        press(B_TIME);
        check("t6_load_hours", int'(bus.hours), 0);
        @(negedge clk);
        btn = B_INC;
        repeat (81) @(negedge clk);
        btn = '0;
        check("t6_autorepeat", int'(bus.hours), 5);
        press(B_CANCEL);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
